// File: rtl/parity_check_bank.sv
// Receive-side parity checker: recomputes per-lane parity from the shared byte and
// per-lane 2-bit fields, flags mismatches and escalates to FAULT after THRESH bad beats.
module parity_check_bank #(
    parameter int LANES  = 8,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4,
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           allbits,
    input  logic [2*LANES-1:0]   onebit,
    input  logic [LANES-1:0]     bitin,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [LANES-1:0]     err_vec,
    output logic [LANES-1:0]     err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [LW-1:0]        first_lane,
    output logic                 first_vld,
    output logic                 fault
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [0:0] {
        ST_OK    = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    function automatic logic lane_parity(input logic [1:0] field, input logic [7:0] data);
        return (^field) ^ (^data);
    endfunction

    logic [LANES-1:0] mismatch_s;
    logic [LW-1:0]    low_idx_s;
    logic             err_beat_s;

    logic             valid_q;
    logic [LANES-1:0] err_vec_q, err_vec_d;
    logic [LANES-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    first_lane_q, first_lane_d;
    logic             first_vld_q, first_vld_d;
    state_t           state_q;
    logic             fault_q;

    // Per-lane mismatch and the lowest failing lane index (scan high to low, last hit wins).
    always_comb begin
        mismatch_s = '0;
        low_idx_s  = '0;
        for (int i = 0; i < LANES; i++) begin
            mismatch_s[i] = bitin[i] ^ lane_parity(onebit[2*i +: 2], allbits);
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            low_idx_s = mismatch_s[i] ? LW'(i) : low_idx_s;
        end
        err_beat_s = in_valid & (|mismatch_s);
    end

    // Next-state for status registers; clr wins over accumulation of a same-cycle beat.
    always_comb begin
        err_vec_d    = in_valid ? mismatch_s : '0;
        sticky_d     = sticky_q;
        cnt_d        = cnt_q;
        first_lane_d = first_lane_q;
        first_vld_d  = first_vld_q;
        if (clr) begin
            sticky_d     = '0;
            cnt_d        = '0;
            first_lane_d = '0;
            first_vld_d  = 1'b0;
        end else if (err_beat_s) begin
            sticky_d = sticky_q | mismatch_s;
            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
            if (!first_vld_q) begin
                first_lane_d = low_idx_s;
                first_vld_d  = 1'b1;
            end else begin
                first_lane_d = first_lane_q;
                first_vld_d  = first_vld_q;
            end
        end else begin
            sticky_d = sticky_q;
            cnt_d    = cnt_q;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            err_vec_q    <= '0;
            sticky_q     <= '0;
            cnt_q        <= '0;
            first_lane_q <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            valid_q      <= in_valid;
            err_vec_q    <= err_vec_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
            first_lane_q <= first_lane_d;
            first_vld_q  <= first_vld_d;
        end
    end

    // OK/FAULT state machine; fault rises on the same edge the counter reaches THRESH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (!clr && err_beat_s && (cnt_d >= THRESH_C)) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_OK;
                        fault_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (clr) begin
                        state_q <= ST_OK;
                        fault_q <= 1'b0;
                    end else begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OK;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign err_vec    = err_vec_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign first_lane = first_lane_q;
    assign first_vld  = first_vld_q;
    assign fault      = fault_q;

endmodule
